// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline definitions: field widths, reset/handler PCs and the entry layout.
package cpu_pipe_pkg;

    localparam int          EXC_W      = 5;
    localparam int          SIDE_W     = 32;
    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    typedef struct packed {
        logic [31:0]       instr;
        logic [31:0]       pc;
        logic [EXC_W-1:0]  exc;
        logic              slot;
        logic [SIDE_W-1:0] side;
        logic              valid;
    } pipe_entry_t;

    // Where the main entry is reloaded from in a given cycle.
    typedef enum logic [1:0] {
        SRC_IN      = 2'd0,
        SRC_SKID    = 2'd1,
        SRC_HANDLER = 2'd2
    } m_src_e;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle between two pipeline stages, plus redirect controls.
interface pipe_stage_buf_if #(
    parameter int SIDE_W = cpu_pipe_pkg::SIDE_W,
    parameter int EXC_W  = cpu_pipe_pkg::EXC_W
);
    logic              req;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [31:0]       in_pc;
    logic [EXC_W-1:0]  in_exc;
    logic              in_slot;
    logic [SIDE_W-1:0] in_side;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic [EXC_W-1:0]  out_exc;
    logic              out_slot;
    logic [SIDE_W-1:0] out_side;
    logic [1:0]        occ;

    modport master (
        output req, flush, in_valid, in_instr, in_pc, in_exc, in_slot, in_side, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_exc, out_slot, out_side, occ
    );

    modport slave (
        input  req, flush, in_valid, in_instr, in_pc, in_exc, in_slot, in_side, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_exc, out_slot, out_side, occ
    );
endinterface

// File: rtl/pipe_stage_buf_entry_reg.sv
// One pipeline entry register with load, bubble-load and valid-clear controls.
module pipe_entry_reg
    import cpu_pipe_pkg::*;
#(
    parameter int          SIDE_W   = 32,
    parameter int          EXC_W    = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              bubble,
    input  logic              clear,
    input  logic [31:0]       d_instr,
    input  logic [31:0]       d_pc,
    input  logic [EXC_W-1:0]  d_exc,
    input  logic              d_slot,
    input  logic [SIDE_W-1:0] d_side,
    output logic              q_valid,
    output logic [31:0]       q_instr,
    output logic [31:0]       q_pc,
    output logic [EXC_W-1:0]  q_exc,
    output logic              q_slot,
    output logic [SIDE_W-1:0] q_side
);

    // Bubbles keep pc/slot so a nullified slot still traces back to its PC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_instr <= '0;
            q_pc    <= RESET_PC;
            q_exc   <= EXC_W'(EXC_NONE);
            q_slot  <= 1'b0;
            q_side  <= '0;
        end else if (load) begin
            q_valid <= 1'b1;
            q_pc    <= d_pc;
            q_slot  <= d_slot;
            q_instr <= bubble ? 32'd0 : d_instr;
            q_exc   <= bubble ? EXC_W'(EXC_NONE) : d_exc;
            q_side  <= bubble ? '0 : d_side;
        end else if (clear) begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry elastic pipeline register (main + skid) with flush-to-bubble and exception redirect.
module pipe_stage_buf
    import cpu_pipe_pkg::*;
#(
    parameter int          SIDE_W     = 32,
    parameter int          EXC_W      = 5,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_stage_buf_if.slave bus
);

    logic              m_valid, s_valid;
    logic [31:0]       s_instr, s_pc;
    logic [EXC_W-1:0]  s_exc;
    logic              s_slot;
    logic [SIDE_W-1:0] s_side;

    logic              accept, drain;
    logic              m_load, m_bubble, m_clear;
    logic              s_load, s_clear;
    m_src_e            m_src;
    logic [31:0]       m_d_instr, m_d_pc;
    logic [EXC_W-1:0]  m_d_exc;
    logic              m_d_slot;
    logic [SIDE_W-1:0] m_d_side;
    logic              m_valid_nxt, s_valid_nxt;
    logic [1:0]        occ_q;

    assign bus.in_ready  = ~s_valid;
    assign bus.out_valid = m_valid;
    assign bus.occ       = occ_q;
    assign accept        = bus.in_valid & ~s_valid;
    assign drain         = m_valid & bus.out_ready;

    always_comb begin
        m_load   = 1'b0;
        m_bubble = 1'b0;
        m_clear  = 1'b0;
        m_src    = SRC_IN;
        s_load   = 1'b0;
        s_clear  = 1'b0;
        if (bus.req) begin
            s_clear  = 1'b1;
            m_load   = 1'b1;
            m_bubble = 1'b1;
            m_src    = SRC_HANDLER;
        end else if (drain && s_valid) begin
            // S already holds a bubble-formatted entry if it was flushed on entry.
            m_load  = 1'b1;
            m_src   = SRC_SKID;
            s_clear = 1'b1;
        end else if (drain || !m_valid) begin
            m_load   = accept;
            m_bubble = bus.flush;
            m_clear  = ~accept;
        end else if (accept) begin
            s_load = 1'b1;
        end
    end

    always_comb begin
        m_d_instr = bus.in_instr;
        m_d_pc    = bus.in_pc;
        m_d_exc   = bus.in_exc;
        m_d_slot  = bus.in_slot;
        m_d_side  = bus.in_side;
        case (m_src)
            SRC_SKID: begin
                m_d_instr = s_instr;
                m_d_pc    = s_pc;
                m_d_exc   = s_exc;
                m_d_slot  = s_slot;
                m_d_side  = s_side;
            end
            SRC_HANDLER: begin
                m_d_pc   = HANDLER_PC;
                m_d_slot = 1'b0;
            end
            default: ;
        endcase
    end

    assign m_valid_nxt = m_load | (m_valid & ~m_clear);
    assign s_valid_nxt = s_load | (s_valid & ~s_clear);

    always_ff @(posedge clk) begin
        if (!rst_n) occ_q <= 2'd0;
        else        occ_q <= {1'b0, m_valid_nxt} + {1'b0, s_valid_nxt};
    end

    pipe_entry_reg #(.SIDE_W(SIDE_W), .EXC_W(EXC_W), .RESET_PC(RESET_PC)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (m_load),
        .bubble  (m_bubble),
        .clear   (m_clear),
        .d_instr (m_d_instr),
        .d_pc    (m_d_pc),
        .d_exc   (m_d_exc),
        .d_slot  (m_d_slot),
        .d_side  (m_d_side),
        .q_valid (m_valid),
        .q_instr (bus.out_instr),
        .q_pc    (bus.out_pc),
        .q_exc   (bus.out_exc),
        .q_slot  (bus.out_slot),
        .q_side  (bus.out_side)
    );

    pipe_entry_reg #(.SIDE_W(SIDE_W), .EXC_W(EXC_W), .RESET_PC(RESET_PC)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (s_load),
        .bubble  (bus.flush),
        .clear   (s_clear),
        .d_instr (bus.in_instr),
        .d_pc    (bus.in_pc),
        .d_exc   (bus.in_exc),
        .d_slot  (bus.in_slot),
        .d_side  (bus.in_side),
        .q_valid (s_valid),
        .q_instr (s_instr),
        .q_pc    (s_pc),
        .q_exc   (s_exc),
        .q_slot  (s_slot),
        .q_side  (s_side)
    );

endmodule
